// File: rtl/cci_mpf_shim_vtp_miss_ctrl.sv
// cci_mpf_shim_vtp_miss_ctrl
//
// Miss controller sitting between the VTP TLB lookup ports and the page
// table walker. Misses from both lookup ports are merged into a small
// pending table with duplicate suppression. One walk is outstanding at a
// time. Each walk result is written to the TLB fill port, and every pending
// entry covered by that fill is retired. A 2MB fill covers a whole 512-page
// region.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   lookup_miss[1:0]              per-port miss strobe
//   lookup_miss_va0/va1           missing 4KB VA page index per port
//   walk_req_valid/va/rdy         walk request handshake (held until rdy)
//   walk_rsp_valid/pa/is_2mb      one-cycle walk completion
//   fill_en/va/pa/rdy             TLB fill handshake (held until rdy)
//   miss_full                     no free pending entry
//   drop_cnt                      saturating count of misses dropped when full
//
// Issue FSM
//   state   | meaning
//   S_IDLE  | pick lowest valid && !issued entry, mark it issued
//   S_REQ   | walk_req_valid high with latched VA, wait for walk_req_rdy
//   S_WAIT  | walk outstanding, wait for walk_rsp_valid
//   S_FILL  | fill_en high, wait for fill_rdy, then retire covered entries

module cci_mpf_shim_vtp_miss_ctrl #(
  parameter int N_PENDING   = 4,
  parameter int VA_IDX_BITS = 36,
  parameter int PA_IDX_BITS = 26
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             lookup_miss,
  input  logic [VA_IDX_BITS-1:0] lookup_miss_va0,
  input  logic [VA_IDX_BITS-1:0] lookup_miss_va1,
  output logic                   walk_req_valid,
  output logic [VA_IDX_BITS-1:0] walk_req_va,
  input  logic                   walk_req_rdy,
  input  logic                   walk_rsp_valid,
  input  logic [PA_IDX_BITS-1:0] walk_rsp_pa,
  input  logic                   walk_rsp_is_2mb,
  output logic                   fill_en,
  output logic [VA_IDX_BITS-1:0] fill_va,
  output logic [PA_IDX_BITS-1:0] fill_pa,
  input  logic                   fill_rdy,
  output logic                   miss_full,
  output logic [15:0]            drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} stateT;

  stateT                  state;
  logic                   fillIs2mb;
  logic [N_PENDING-1:0]   entValid;
  logic [N_PENDING-1:0]   entIssued;
  logic [VA_IDX_BITS-1:0] entVa [N_PENDING];

  logic                   fillFire;
  logic [N_PENDING-1:0]   retireMask;
  logic [N_PENDING-1:0]   allocMask0;
  logic [N_PENDING-1:0]   allocMask1;
  logic [N_PENDING-1:0]   selMask;
  logic [N_PENDING-1:0]   validNext;
  logic [N_PENDING-1:0]   issuedNext;
  logic [VA_IDX_BITS-1:0] selVa;
  logic                   hit0, hit1, drop0, drop1;
  logic                   found0, found1, foundSel;
  logic [1:0]             dropInc;
  logic [16:0]            dropSum;

  // A fill covers a VA either exactly (4KB) or by its 2MB region.
  function automatic logic fillCovers(input logic [VA_IDX_BITS-1:0] va,
                                      input logic [VA_IDX_BITS-1:0] fva,
                                      input logic                   is2mb);
    if (is2mb) return va[VA_IDX_BITS-1:9] == fva[VA_IDX_BITS-1:9];
    return va == fva;
  endfunction

  always_comb begin
    fillFire   = fill_en && fill_rdy;
    retireMask = '0;
    allocMask0 = '0;
    allocMask1 = '0;
    selMask    = '0;
    selVa      = '0;
    found0     = 1'b0;
    found1     = 1'b0;
    foundSel   = 1'b0;
    drop0      = 1'b0;
    drop1      = 1'b0;

    // A miss covered by a fill completing this cycle is already satisfied.
    hit0 = fillFire && fillCovers(lookup_miss_va0, fill_va, fillIs2mb);
    hit1 = fillFire && fillCovers(lookup_miss_va1, fill_va, fillIs2mb);

    for (int i = 0; i < N_PENDING; i++) begin
      retireMask[i] = fillFire && entValid[i] && fillCovers(entVa[i], fill_va, fillIs2mb);
      if (entValid[i] && (entVa[i] == lookup_miss_va0)) hit0 = 1'b1;
      if (entValid[i] && (entVa[i] == lookup_miss_va1)) hit1 = 1'b1;
    end

    // Allocation only uses entries free at the start of the cycle, so an
    // entry retired this cycle is not handed out until the next one.
    if (lookup_miss[0] && !hit0) begin
      for (int i = 0; i < N_PENDING; i++) begin
        if (!entValid[i] && !found0) begin
          allocMask0[i] = 1'b1;
          found0        = 1'b1;
        end
      end
      drop0 = !found0;
    end

    // Port 1 matching a port 0 miss that was kept shares its entry.
    if (lookup_miss[0] && !drop0 && (lookup_miss_va1 == lookup_miss_va0)) hit1 = 1'b1;

    if (lookup_miss[1] && !hit1) begin
      for (int i = 0; i < N_PENDING; i++) begin
        if (!entValid[i] && !allocMask0[i] && !found1) begin
          allocMask1[i] = 1'b1;
          found1        = 1'b1;
        end
      end
      drop1 = !found1;
    end

    for (int i = 0; i < N_PENDING; i++) begin
      if (entValid[i] && !entIssued[i] && !foundSel) begin
        selMask[i] = 1'b1;
        selVa      = entVa[i];
        foundSel   = 1'b1;
      end
    end

    validNext  = (entValid & ~retireMask) | allocMask0 | allocMask1;
    issuedNext = ((entIssued & ~retireMask) | ((state == S_IDLE) ? selMask : '0))
                 & ~(allocMask0 | allocMask1);

    dropInc = {1'b0, drop0} + {1'b0, drop1};
    dropSum = {1'b0, drop_cnt} + {15'b0, dropInc};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      walk_req_valid <= 1'b0;
      walk_req_va    <= '0;
      fill_en        <= 1'b0;
      fill_va        <= '0;
      fill_pa        <= '0;
      fillIs2mb      <= 1'b0;
      miss_full      <= 1'b0;
      drop_cnt       <= '0;
      entValid       <= '0;
      entIssued      <= '0;
      for (int i = 0; i < N_PENDING; i++) entVa[i] <= '0;
    end else begin
      entValid  <= validNext;
      entIssued <= issuedNext;
      for (int i = 0; i < N_PENDING; i++) begin
        if (allocMask0[i])      entVa[i] <= lookup_miss_va0;
        else if (allocMask1[i]) entVa[i] <= lookup_miss_va1;
      end
      miss_full <= &validNext;
      drop_cnt  <= dropSum[16] ? 16'hFFFF : dropSum[15:0];

      case (state)
        S_IDLE: begin
          if (foundSel) begin
            walk_req_va    <= selVa;
            walk_req_valid <= 1'b1;
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          if (walk_req_rdy) begin
            walk_req_valid <= 1'b0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (walk_rsp_valid) begin
            fill_en   <= 1'b1;
            fillIs2mb <= walk_rsp_is_2mb;
            if (walk_rsp_is_2mb) begin
              fill_va <= {walk_req_va[VA_IDX_BITS-1:9], 9'b0};
              fill_pa <= {walk_rsp_pa[PA_IDX_BITS-1:9], 9'b0};
            end else begin
              fill_va <= walk_req_va;
              fill_pa <= walk_rsp_pa;
            end
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (fill_rdy) begin
            fill_en <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cci_mpf_shim_vtp_miss_ctrl.sv
// Testbench for cci_mpf_shim_vtp_miss_ctrl: directed scenarios followed by
// randomized traffic, all outputs compared every cycle against a
// transaction-level model of the pending table and walk sequence.

module tb_cci_mpf_shim_vtp_miss_ctrl;

  localparam int N   = 4;
  localparam int VAW = 36;
  localparam int PAW = 26;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     lookup_miss;
  logic [VAW-1:0] va0, va1;
  logic           walk_req_valid;
  logic [VAW-1:0] walk_req_va;
  logic           walk_req_rdy;
  logic           walk_rsp_valid;
  logic [PAW-1:0] walk_rsp_pa;
  logic           walk_rsp_is_2mb;
  logic           fill_en;
  logic [VAW-1:0] fill_va;
  logic [PAW-1:0] fill_pa;
  logic           fill_rdy;
  logic           miss_full;
  logic [15:0]    drop_cnt;

  always #5 clk = ~clk;

  cci_mpf_shim_vtp_miss_ctrl #(.N_PENDING(N), .VA_IDX_BITS(VAW), .PA_IDX_BITS(PAW)) dut (
    .clk(clk), .reset_n(reset_n),
    .lookup_miss(lookup_miss), .lookup_miss_va0(va0), .lookup_miss_va1(va1),
    .walk_req_valid(walk_req_valid), .walk_req_va(walk_req_va), .walk_req_rdy(walk_req_rdy),
    .walk_rsp_valid(walk_rsp_valid), .walk_rsp_pa(walk_rsp_pa), .walk_rsp_is_2mb(walk_rsp_is_2mb),
    .fill_en(fill_en), .fill_va(fill_va), .fill_pa(fill_pa), .fill_rdy(fill_rdy),
    .miss_full(miss_full), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- responder (walker + TLB fill side) ----------------
  int             pReqRdy = 100, pRsp = 100, pFill = 100;
  bit             randRsp = 1'b0;
  logic [PAW-1:0] rspPaD  = '0;
  logic           rsp2mbD = 1'b0;

  initial begin
    walk_req_rdy = 1'b0; walk_rsp_valid = 1'b0; fill_rdy = 1'b0;
    walk_rsp_pa = '0; walk_rsp_is_2mb = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      walk_req_rdy   = ($urandom_range(0, 99) < pReqRdy);
      walk_rsp_valid = ($urandom_range(0, 99) < pRsp);
      fill_rdy       = ($urandom_range(0, 99) < pFill);
      if (randRsp) begin
        walk_rsp_pa     = PAW'($urandom);
        walk_rsp_is_2mb = ($urandom_range(0, 2) == 0);
      end else begin
        walk_rsp_pa     = rspPaD;
        walk_rsp_is_2mb = rsp2mbD;
      end
    end
  end

  // ---------------- handshake monitor ----------------
  int             nReq = 0, nFill = 0;
  logic [VAW-1:0] reqLog[$];

  always @(posedge clk) begin
    if (walk_req_valid && walk_req_rdy) begin
      nReq++;
      reqLog.push_back(walk_req_va);
    end
    if (fill_en && fill_rdy) nFill++;
  end

  // ---------------- behavioural model ----------------
  // Table of pending misses plus the walk phase (0 idle, 1 request,
  // 2 walk outstanding, 3 fill pending) and the expected outputs.
  bit             mV[N], mI[N];
  logic [VAW-1:0] mVa[N];
  int             phase = 0;
  bit             started = 1'b0;
  bit             eReqV = 0, eFillEn = 0, eFull = 0, eIs2mb = 0;
  logic [VAW-1:0] eReqVa = '0, eFillVa = '0;
  logic [PAW-1:0] eFillPa = '0;
  int             eDrop = 0;

  function automatic bit covers(input logic [VAW-1:0] v);
    if (eIs2mb) return (v >> 9) == (eFillVa >> 9);
    return v == eFillVa;
  endfunction

  always @(posedge clk) begin : model
    bit             fire, absorb, dropped0, doAlloc[2];
    bit             taken[N];
    int             slot, drops, sel;
    int             aSlot[2];
    logic [VAW-1:0] aVa[2];
    logic [VAW-1:0] pv;
    started = 1'b1;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin mV[i] = 0; mI[i] = 0; mVa[i] = '0; end
      phase = 0; eReqV = 0; eFillEn = 0; eFull = 0; eIs2mb = 0;
      eReqVa = '0; eFillVa = '0; eFillPa = '0; eDrop = 0;
    end else begin
      fire = (phase == 3) && fill_rdy;
      drops = 0; dropped0 = 0;
      for (int i = 0; i < N; i++) taken[i] = mV[i];
      for (int p = 0; p < 2; p++) begin
        doAlloc[p] = 0;
        if (lookup_miss[p]) begin
          pv = (p == 0) ? va0 : va1;
          absorb = fire && covers(pv);
          for (int i = 0; i < N; i++) if (mV[i] && mVa[i] == pv) absorb = 1;
          if (p == 1 && lookup_miss[0] && pv == va0 && !dropped0) absorb = 1;
          if (!absorb) begin
            slot = -1;
            for (int i = 0; i < N; i++) if (!taken[i] && slot < 0) slot = i;
            if (slot < 0) begin
              drops++;
              if (p == 0) dropped0 = 1;
            end else begin
              taken[slot] = 1; doAlloc[p] = 1; aSlot[p] = slot; aVa[p] = pv;
            end
          end
        end
      end
      case (phase)
        0: begin
          sel = -1;
          for (int i = 0; i < N; i++) if (mV[i] && !mI[i] && sel < 0) sel = i;
          if (sel >= 0) begin
            mI[sel] = 1; eReqVa = mVa[sel]; eReqV = 1; phase = 1;
          end
        end
        1: if (walk_req_rdy) begin eReqV = 0; phase = 2; end
        2: if (walk_rsp_valid) begin
          eIs2mb = walk_rsp_is_2mb;
          if (walk_rsp_is_2mb) begin
            eFillVa = (eReqVa >> 9) << 9;
            eFillPa = (walk_rsp_pa >> 9) << 9;
          end else begin
            eFillVa = eReqVa;
            eFillPa = walk_rsp_pa;
          end
          eFillEn = 1; phase = 3;
        end
        default: if (fill_rdy) begin
          for (int i = 0; i < N; i++) if (mV[i] && covers(mVa[i])) begin mV[i] = 0; mI[i] = 0; end
          eFillEn = 0; phase = 0;
        end
      endcase
      for (int p = 0; p < 2; p++)
        if (doAlloc[p]) begin mV[aSlot[p]] = 1; mI[aSlot[p]] = 0; mVa[aSlot[p]] = aVa[p]; end
      eDrop = (eDrop + drops > 65535) ? 65535 : eDrop + drops;
      eFull = 1;
      for (int i = 0; i < N; i++) if (!mV[i]) eFull = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("walk_req_valid", 64'(walk_req_valid), 64'(eReqV));
      chk("walk_req_va",    64'(walk_req_va),    64'(eReqVa));
      chk("fill_en",        64'(fill_en),        64'(eFillEn));
      chk("fill_va",        64'(fill_va),        64'(eFillVa));
      chk("fill_pa",        64'(fill_pa),        64'(eFillPa));
      chk("miss_full",      64'(miss_full),      64'(eFull));
      chk("drop_cnt",       64'(drop_cnt),       64'(eDrop));
    end
  end

  // ---------------- bounded waits ----------------
  task automatic waitReq(input string what, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (walk_req_valid) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL timeout %s: walk_req_valid not seen within %0d cycles", what, budget);
  endtask

  task automatic waitFill(input string what, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (fill_en) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL timeout %s: fill_en not seen within %0d cycles", what, budget);
  endtask

  function automatic logic [VAW-1:0] randVa();
    logic [VAW-1:0] v;
    v = VAW'($urandom_range(0, 3)) << 9;
    v = v | VAW'($urandom_range(0, 5));
    if ($urandom_range(0, 7) == 0) v[VAW-1] = 1'b1;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  int n0, f0, nLog;

  initial begin
    reset_n = 1'b0; lookup_miss = 2'b00; va0 = '0; va1 = '0;
    tick(); tick(); tick();
    chk("reset walk_req_valid", 64'(walk_req_valid), 64'd0);
    chk("reset fill_en",        64'(fill_en),        64'd0);
    chk("reset drop_cnt",       64'(drop_cnt),       64'd0);
    chk("reset miss_full",      64'(miss_full),      64'd0);
    reset_n = 1'b1;
    rspPaD = 26'h00456; rsp2mbD = 1'b0;
    tick(); tick();

    // Single miss
    lookup_miss = 2'b01; va0 = 36'h000123; tick();
    lookup_miss = 2'b00;
    chk("single req at t+1", 64'(walk_req_valid), 64'd0);
    tick();
    chk("single req at t+2", 64'(walk_req_valid), 64'd1);
    chk("single req va",     64'(walk_req_va),    64'h123);
    tick();
    chk("single no fill yet", 64'(fill_en), 64'd0);
    tick();
    chk("single fill_en", 64'(fill_en), 64'd1);
    chk("single fill_va", 64'(fill_va), 64'h123);
    chk("single fill_pa", 64'(fill_pa), 64'h456);
    tick();
    chk("single fill done", 64'(fill_en), 64'd0);
    n0 = nReq;
    repeat (4) tick();
    chk("single table empty", 64'(nReq - n0), 64'd0);

    // Duplicates
    n0 = nReq; f0 = nFill;
    lookup_miss = 2'b11; va0 = 36'h0000A0; va1 = 36'h0000A0; tick();
    lookup_miss = 2'b00; tick(); tick();
    lookup_miss = 2'b01; tick();
    lookup_miss = 2'b00;
    repeat (10) tick();
    chk("dup walk count", 64'(nReq - n0),  64'd1);
    chk("dup fill count", 64'(nFill - f0), 64'd1);
    chk("dup drop_cnt",   64'(drop_cnt),   64'd0);

    // Overflow
    pReqRdy = 0; tick();
    for (int k = 0; k < 6; k++) begin
      lookup_miss = 2'b01; va0 = 36'h10 + VAW'(k); tick();
    end
    lookup_miss = 2'b00; tick();
    chk("ovf miss_full", 64'(miss_full), 64'd1);
    chk("ovf drop_cnt",  64'(drop_cnt),  64'd2);
    reqLog.delete();
    pReqRdy = 100;
    repeat (40) tick();
    nLog = reqLog.size();
    chk("ovf walk count", 64'(nLog), 64'd4);
    for (int i = 0; i < 4 && i < nLog; i++) chk("ovf walk order", 64'(reqLog[i]), 64'h10 + 64'(i));
    chk("ovf drained miss_full", 64'(miss_full), 64'd0);

    // 2MB coalesce
    pReqRdy = 0; tick();
    lookup_miss = 2'b01; va0 = 36'h000200; tick();
    va0 = 36'h000305; tick();
    va0 = 36'h000400; tick();
    lookup_miss = 2'b00;
    rsp2mbD = 1'b1; rspPaD = 26'h00A17; pFill = 0; pReqRdy = 100;
    waitFill("2mb fill", 20);
    chk("2mb fill_va", 64'(fill_va), 64'h200);
    chk("2mb fill_pa", 64'(fill_pa), 64'hA00);
    rsp2mbD = 1'b0; reqLog.delete(); pFill = 100;
    tick();
    waitReq("2mb next walk", 20);
    chk("2mb next walk va", 64'(walk_req_va), 64'h400);
    repeat (12) tick();
    chk("2mb walks after coalesce", 64'(reqLog.size()), 64'd1);

    // Backpressure on fill
    pFill = 0; tick();
    lookup_miss = 2'b01; va0 = 36'h000777; tick();
    lookup_miss = 2'b00;
    waitFill("bp fill", 20);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin lookup_miss = 2'b01; va0 = 36'h000777; end
      else lookup_miss = 2'b00;
      tick();
      chk("bp fill_en held",   64'(fill_en),        64'd1);
      chk("bp fill_va held",   64'(fill_va),        64'h777);
      chk("bp fill_pa held",   64'(fill_pa),        64'hA17);
      chk("bp no walk_req",    64'(walk_req_valid), 64'd0);
    end
    lookup_miss = 2'b00; n0 = nReq; pFill = 100;
    repeat (8) tick();
    chk("bp same-va absorbed", 64'(nReq - n0), 64'd0);

    // Reset mid-walk
    pRsp = 0; tick();
    lookup_miss = 2'b01; va0 = 36'h000055; tick();
    lookup_miss = 2'b00;
    waitReq("rst walk", 10);
    tick(); tick();
    reset_n = 1'b0; tick(); tick();
    reset_n = 1'b1; pRsp = 100; f0 = nFill;
    repeat (6) tick();
    chk("rst fill_en",        64'(fill_en),        64'd0);
    chk("rst walk_req_valid", 64'(walk_req_valid), 64'd0);
    chk("rst walk_req_va",    64'(walk_req_va),    64'd0);
    chk("rst fill_va",        64'(fill_va),        64'd0);
    chk("rst fill_pa",        64'(fill_pa),        64'd0);
    chk("rst drop_cnt",       64'(drop_cnt),       64'd0);
    chk("rst no fills",       64'(nFill - f0),     64'd0);

    // Randomized traffic with occasional resets
    randRsp = 1'b1; pReqRdy = 60; pRsp = 40; pFill = 60;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        pReqRdy = int'($urandom_range(20, 100));
        pRsp    = int'($urandom_range(10, 100));
        pFill   = int'($urandom_range(20, 100));
      end
      lookup_miss = 2'($urandom_range(0, 3));
      va0 = randVa();
      va1 = ($urandom_range(0, 3) == 0) ? va0 : randVa();
      reset_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    lookup_miss = 2'b00; reset_n = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_vtp_miss_ctrl.md
# cci_mpf_shim_vtp_miss_ctrl

Miss controller between the VTP TLB and the page table walker. It collects TLB miss reports from both lookup ports and removes duplicates in a small pending table. It issues one walk at a time to the walker, then drives the TLB fill port with the result and retires every pending entry the fill covers. All addresses are 4KB line-address page indices, with 2MB pages expressed as 4KB indices whose low 9 bits are zero.

## Interface
- N_PENDING, 4: pending-miss table entries (2..16).
- VA_IDX_BITS, 36: 4KB VA page index width.
- PA_IDX_BITS, 26: 4KB PA page index width.
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- lookup_miss  in  2  per-port miss strobe (bit i = TLB port i).
- lookup_miss_va0 / lookup_miss_va1  in  VA_IDX_BITS  missing page, qualified by lookup_miss[i].
- walk_req_valid  out  1  walk request.
- walk_req_va  out  VA_IDX_BITS  page to walk.
- walk_req_rdy  in  1  walker accepts.
- walk_rsp_valid  in  1  one-cycle walk completion.
- walk_rsp_pa  in  PA_IDX_BITS  translated page.
- walk_rsp_is_2mb  in  1  translation is a 2MB page.
- fill_en  out  1  TLB fill request.
- fill_va  out  VA_IDX_BITS  fill VA.
- fill_pa  out  PA_IDX_BITS  fill PA.
- fill_rdy  in  1  TLB accepts fill.
- miss_full  out  1  no free pending entry.
- drop_cnt  out  16  saturating count of misses discarded for lack of space.

## Operation
- Table entry: valid, issued, va. Reset clears all valid bits.
- Capture each cycle, port 0 before port 1:
  - A miss whose va equals any valid entry's va is absorbed (no new entry).
  - If both ports miss the same va in one cycle, one entry is created.
  - Otherwise the miss allocates the lowest-index free entry.
  - If no entry is free, the miss is dropped and drop_cnt increments (saturates at 0xFFFF, +2 if both dropped). The VTP pipeline replays dropped lookups.
- Issue FSM:
  - IDLE: select the lowest-index entry with valid && !issued, latch its va, set issued, go to REQ.
  - REQ: walk_req_valid=1 with the latched va, held stable. On walk_req_rdy go to WAIT.
  - WAIT: on walk_rsp_valid, latch the result and go to FILL.
    - 4KB: fill_va = latched va, fill_pa = walk_rsp_pa.
    - 2MB: fill_va = {va[VA_IDX_BITS-1:9], 9'b0}, fill_pa = {walk_rsp_pa[PA_IDX_BITS-1:9], 9'b0}.
  - FILL: fill_en=1, held stable. On fill_rdy, retire entries and go to IDLE.
    - 4KB fill retires the entry with va == fill_va.
    - 2MB fill retires every valid entry with va[VA_IDX_BITS-1:9] == fill_va[VA_IDX_BITS-1:9].
    - Retirement covers issued and unissued entries.
- Same-cycle events:
  - A miss arriving in the fill_rdy handshake cycle that the fill covers is absorbed, not allocated.
  - Retirement and allocation in the same cycle: the freed entry is not reusable until the next cycle.
- miss_full = no invalid entry (registered, reflects table state at the start of the cycle).

## Timing
- Reset: walk_req_valid=0, fill_en=0, walk_req_va=0, fill_va=0, fill_pa=0, miss_full=0, drop_cnt=0, FSM=IDLE, table empty.
- Reset mid-walk: all state is discarded. A late walk_rsp_valid after reset is ignored in IDLE/REQ.
- Latency: a miss at cycle t into an empty table with FSM IDLE gives walk_req_valid at t+2.
  - t+1: entry valid.
  - t+2: request registered.
- walk_rsp_valid at cycle r gives fill_en at r+1. A fill accepted at cycle f gives walk_req_valid for the next entry no earlier than f+2.
- walk_rsp_valid outside WAIT is ignored.
- All outputs are registered. walk_req_rdy and fill_rdy are sampled only while the corresponding valid is high.

## Test plan
- Single miss: va0=0x000123 on port 0, walker rdy immediately, rsp pa=0x00456 4KB one cycle later -> walk_req_va=0x000123 at t+2, fill_en with fill_va=0x000123, fill_pa=0x00456, table empty after fill_rdy.
- Duplicates: both ports miss 0x0000A0 at cycle t, port 0 repeats at t+3 -> exactly one walk_req, one fill, drop_cnt=0.
- Overflow (N_PENDING=4, walk_req_rdy=0): 6 distinct misses on port 0 -> 4 entries, miss_full=1, drop_cnt=2. Walks then issue in index order.
- 2MB coalesce: pending 0x000200, 0x000305, 0x000400. Walk of 0x000200 returns is_2mb, pa=0x00A17 -> fill_va=0x000200, fill_pa=0x00A00. Entries 0x000200 and 0x000305 retire; next walk is 0x000400.
- Backpressure: fill_rdy=0 for 5 cycles -> fill_en, fill_va and fill_pa stable, no new walk_req. A same-VA miss during FILL is absorbed.
- Reset mid-operation: reset_n=0 during WAIT, then walk_rsp_valid after release -> no fill_en, all outputs at reset values, drop_cnt=0.
